// File: rtl/fetch_redirect_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fetch_redirect_arbiter
// Purpose  : Ranks PC-redirect requests (trap > br0 > br1 > dec), holds the
//            winner until the fetch PC generator accepts it, pulses flushes,
//            and masks stale decode redirects for a drain window after accept.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_redirect_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  br0_redirect,
  input  logic [ADDR_WIDTH-1:0] br0_pc,
  input  logic                  br1_redirect,
  input  logic [ADDR_WIDTH-1:0] br1_pc,
  input  logic                  dec_redirect,
  input  logic [ADDR_WIDTH-1:0] dec_pc,
  input  logic                  trap_req,
  input  logic [ADDR_WIDTH-1:0] trap_pc,
  input  logic                  fetch_ready,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [1:0]            redirect_src,
  output logic                  flush_frontend,
  output logic                  flush_backend,
  output logic                  misaligned,
  output logic [15:0]           redirect_count
);

  // Counter must hold DRAIN_CYCLES itself; keep at least one bit when disabled.
  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  localparam logic [1:0] SRC_DEC  = 2'd0;
  localparam logic [1:0] SRC_BR1  = 2'd1;
  localparam logic [1:0] SRC_BR0  = 2'd2;
  localparam logic [1:0] SRC_TRAP = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:2]   pc_q, pc_d;
  logic [1:0]              src_q, src_d;
  logic [CNT_W-1:0]        drain_q, drain_d;
  logic                    flush_fe_q, flush_fe_d;
  logic                    flush_be_q, flush_be_d;
  logic                    misaligned_q, misaligned_d;
  logic [15:0]             count_q, count_d;

  logic                    accept;
  logic                    allow_trap, allow_br, allow_dec;
  logic                    cap;
  logic [ADDR_WIDTH-1:0]   sel_pc;
  logic [1:0]              sel_src;

  // Which request classes may be captured in the current state.
  // HOLD only admits a trap over a non-trap entry, except on the accept cycle
  // where the slot is being freed and any trap/branch may take it.
  assign accept     = (state_q == ST_HOLD) && fetch_ready;
  assign allow_trap = (state_q != ST_HOLD) || accept || (src_q != SRC_TRAP);
  assign allow_br   = (state_q != ST_HOLD) || accept;
  assign allow_dec  = (state_q == ST_IDLE);

  // Fixed-priority pick among admissible requests.
  always_comb begin
    cap     = 1'b0;
    sel_pc  = '0;
    sel_src = SRC_DEC;
    if (trap_req && allow_trap) begin
      cap     = 1'b1;
      sel_pc  = trap_pc;
      sel_src = SRC_TRAP;
    end else if (br0_redirect && allow_br) begin
      cap     = 1'b1;
      sel_pc  = br0_pc;
      sel_src = SRC_BR0;
    end else if (br1_redirect && allow_br) begin
      cap     = 1'b1;
      sel_pc  = br1_pc;
      sel_src = SRC_BR1;
    end else if (dec_redirect && allow_dec) begin
      cap     = 1'b1;
      sel_pc  = dec_pc;
      sel_src = SRC_DEC;
    end
  end

  // Next-state, held entry, drain counter, flush pulses and statistics.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    src_d        = src_q;
    drain_d      = drain_q;
    flush_fe_d   = cap;
    flush_be_d   = cap && (sel_src != SRC_DEC);
    misaligned_d = misaligned_q || (cap && (sel_pc[1:0] != 2'b00));
    count_d      = (accept && (count_q != 16'hFFFF)) ? count_q + 16'd1 : count_q;

    if (cap) begin
      // A capture always wins: it (re)fills the slot and abandons any drain.
      state_d = ST_HOLD;
      pc_d    = sel_pc[ADDR_WIDTH-1:2];
      src_d   = sel_src;
      drain_d = '0;
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          if (fetch_ready) begin
            if (DRAIN_CYCLES == 0) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DRAIN;
              drain_d = DRAIN_LOAD;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_q <= CNT_ONE) begin
            state_d = ST_IDLE;
            drain_d = '0;
          end else begin
            drain_d = drain_q - CNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers; reset discards any pending redirect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= '0;
      src_q        <= SRC_DEC;
      drain_q      <= '0;
      flush_fe_q   <= 1'b0;
      flush_be_q   <= 1'b0;
      misaligned_q <= 1'b0;
      count_q      <= 16'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      src_q        <= src_d;
      drain_q      <= drain_d;
      flush_fe_q   <= flush_fe_d;
      flush_be_q   <= flush_be_d;
      misaligned_q <= misaligned_d;
      count_q      <= count_d;
    end
  end

  assign redirect_valid = (state_q == ST_HOLD);
  assign redirect_pc    = {pc_q, 2'b00};
  assign redirect_src   = src_q;
  assign flush_frontend = flush_fe_q;
  assign flush_backend  = flush_be_q;
  assign misaligned     = misaligned_q;
  assign redirect_count = count_q;

endmodule
`default_nettype wire

// File: doc/fetch_redirect_arbiter.md
# fetch_redirect_arbiter

Collects PC-redirect requests from the two branch-resolution slots, the decode-stage target check and the trap unit. It selects one redirect per event, holds it until the fetch PC generator accepts it, and issues frontend/backend flush pulses. After each accepted redirect it enforces a drain window that masks stale wrong-path decode redirects. It sits between the execute/decode/trap feedback paths and the next-PC predictor's redirect input.

## Interface
Parameters:
- ADDR_WIDTH, 32: PC width.
- DRAIN_CYCLES, 2: cycles after acceptance during which decode redirects are ignored. 0 disables the window.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- br0_redirect  in  1  branch slot 0 (older slot) mispredicted.
- br0_pc  in  ADDR_WIDTH  slot 0 corrected PC.
- br1_redirect  in  1  branch slot 1 (younger slot) mispredicted.
- br1_pc  in  ADDR_WIDTH  slot 1 corrected PC.
- dec_redirect  in  1  decode-stage target correction.
- dec_pc  in  ADDR_WIDTH  decode corrected PC.
- trap_req  in  1  trap/exception entry.
- trap_pc  in  ADDR_WIDTH  trap vector.
- fetch_ready  in  1  PC generator accepts the redirect this cycle.
- redirect_valid  out  1  redirect pending.
- redirect_pc  out  ADDR_WIDTH  pending target, bits [1:0] forced 0.
- redirect_src  out  2  source: 0 dec, 1 br1, 2 br0, 3 trap.
- flush_frontend  out  1  one-cycle pulse on capture.
- flush_backend  out  1  one-cycle pulse on capture of a trap/br0/br1 redirect.
- misaligned  out  1  sticky: a captured PC had nonzero bits [1:0].
- redirect_count  out  16  accepted redirects, saturating at 16'hFFFF.

## Operation
- Source rank, highest first: trap (3) > br0 (2) > br1 (1) > dec (0). Among simultaneous requests, only the highest-ranked one is captured. The rest are dropped.
- FSM states:
  - IDLE: a valid request is captured into pc/src registers. Go to HOLD.
  - HOLD: redirect_valid=1. On redirect_valid && fetch_ready (accept), go to DRAIN, or to IDLE if DRAIN_CYCLES=0. While in HOLD, a new trap_req overwrites a held non-trap entry (src, pc updated, flush pulses re-issued). All other new requests are dropped.
  - DRAIN: a down-counter is loaded with DRAIN_CYCLES on accept and decrements each cycle. Go to IDLE when it reaches 1→0. dec_redirect is ignored. trap/br0/br1 requests are captured as in IDLE (go to HOLD, counter abandoned).
- Accept cycle with a simultaneous new trap/br request: the new request is captured. State stays HOLD, and redirect_count still increments for the accepted one.
- A held trap is never overwritten. A second trap while holding a trap is dropped.
- redirect_pc outputs the captured PC with bits [1:0] cleared. misaligned is set if the raw bits were nonzero, and is cleared only by reset.
- redirect_pc and redirect_src stay stable while redirect_valid=1 && !fetch_ready, except for a trap override.
- Reset (any cycle, including mid-HOLD): state IDLE, pending redirect discarded, all outputs 0, redirect_count 0, drain counter 0.

## Timing
- Capture latency is 1 cycle. A request at edge N gives redirect_valid, redirect_pc, redirect_src and flush pulses valid after edge N+1.
- flush_frontend and flush_backend are high for exactly one cycle per capture or override. They are never asserted without a capture.
- Accept happens on the edge where redirect_valid && fetch_ready. redirect_valid deasserts after that edge unless a new capture occurred on the same edge.
- DRAIN spans DRAIN_CYCLES cycles following the accept edge. A dec_redirect on any of those cycles produces no output.
- redirect_count increments on the accept edge and is visible the following cycle.

## Test plan
- Single br1 request, pc=0x1000, fetch_ready=1 → next cycle: redirect_valid=1, src=1, pc=0x1000, both flush pulses. Accepted that cycle; redirect_count=1.
- Simultaneous dec(0x40), br1(0x80), br0(0xC0) → src=2, pc=0xC0, single flush pair, count=1 after accept.
- br0 (0x200) held with fetch_ready=0 for 3 cycles; trap (0x8) arrives in cycle 2 → src=3, pc=0x8, second flush pair. A later br1 while holding the trap is dropped. On accept, count=1.
- DRAIN_CYCLES=2: accept, then dec_redirect on the two following cycles → no redirect_valid. dec_redirect on the 3rd cycle → captured, src=0.
- dec_pc=0x103 → redirect_pc=0x100, misaligned=1 and still 1 after accept. flush_backend=0.
- Assert reset low while in HOLD → immediately redirect_valid=0, count=0, flushes 0. After release, the first request is captured normally.
